// File: rtl/cdc_word_send_arbiter_pkg.sv
// Shared elaboration-time helpers for the CDC word send arbiter.
package cdc_word_send_arbiter_pkg;

    function automatic int clog2_int(input int value);
        for (int r = 0; r < 31; r++) begin
            if ((1 << r) >= value) return r;
        end
        return 31;
    endfunction

    // Index field is never narrower than one bit, even for a single requester.
    function automatic int index_width(input int count);
        return (clog2_int(count) < 1) ? 1 : clog2_int(count);
    endfunction

endpackage

// File: rtl/arbiter_round_robin_priority.sv
// Combinational round-robin priority pick: the first request at or after pointer,
// wrapping past the last requester, as a one-hot grant.
module arbiter_round_robin_priority #(
    parameter int REQUESTER_COUNT = 4,
    parameter int INDEX_WIDTH     = 2
) (
    input  logic [REQUESTER_COUNT-1:0] requests,
    input  logic [INDEX_WIDTH-1:0]     pointer,
    output logic [REQUESTER_COUNT-1:0] grant
);

    int   idx;
    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int offset = 0; offset < REQUESTER_COUNT; offset++) begin
            idx = (int'(pointer) + offset) % REQUESTER_COUNT;
            if (!found && requests[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdc_word_send_arbiter.sv
// Round-robin arbiter sharing one CDC word synchronizer's sending port, tagging each
// word with its requester index and sequencing the sending-side clear after reset.
//
// state       | meaning
// ST_CLEARING | sync_clear high; counts CLEAR_CYCLES cycles after reset release
// ST_IDLE     | sync_valid low; grants the next valid requester combinationally
// ST_BUSY     | word held on sync_data with sync_valid until the sync_ready pulse
module cdc_word_send_arbiter
    import cdc_word_send_arbiter_pkg::*;
#(
    parameter int  REQUESTER_COUNT = 4,
    parameter int  WORD_WIDTH      = 8,
    parameter int  CLEAR_CYCLES    = 3,
    localparam int INDEX_WIDTH     = index_width(REQUESTER_COUNT)
) (
    input  logic                                  clock,
    input  logic                                  clear_n,
    input  logic [REQUESTER_COUNT*WORD_WIDTH-1:0] requester_data,
    input  logic [REQUESTER_COUNT-1:0]            requester_valid,
    output logic [REQUESTER_COUNT-1:0]            requester_ready,
    output logic [INDEX_WIDTH+WORD_WIDTH-1:0]     sync_data,
    output logic                                  sync_valid,
    input  logic                                  sync_ready,
    output logic                                  sync_clear
);

    localparam logic [1:0] ST_CLEARING = 2'd0;
    localparam logic [1:0] ST_IDLE     = 2'd1;
    localparam logic [1:0] ST_BUSY     = 2'd2;

    localparam int COUNT_WIDTH = clog2_int(CLEAR_CYCLES + 1);

    logic [1:0]                 state;
    logic [COUNT_WIDTH-1:0]     clear_count;
    logic [INDEX_WIDTH-1:0]     pointer;
    logic [INDEX_WIDTH-1:0]     next_pointer;
    logic [REQUESTER_COUNT-1:0] grant;
    logic [INDEX_WIDTH-1:0]     grant_index;
    logic [WORD_WIDTH-1:0]      grant_word;
    logic                       grant_enable;

    arbiter_round_robin_priority #(
        .REQUESTER_COUNT (REQUESTER_COUNT),
        .INDEX_WIDTH     (INDEX_WIDTH)
    ) u_priority (
        .requests (requester_valid),
        .pointer  (pointer),
        .grant    (grant)
    );

    assign grant_enable    = clear_n && (state == ST_IDLE);
    assign requester_ready = grant_enable ? grant : '0;

    always_comb begin
        grant_index = '0;
        for (int i = 0; i < REQUESTER_COUNT; i++) begin
            if (grant[i]) grant_index = grant_index | INDEX_WIDTH'(i);
        end
    end

    assign grant_word   = requester_data[int'(grant_index)*WORD_WIDTH +: WORD_WIDTH];
    assign next_pointer = (grant_index == INDEX_WIDTH'(REQUESTER_COUNT - 1)) ?
                          '0 : grant_index + INDEX_WIDTH'(1);

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            state       <= ST_CLEARING;
            clear_count <= COUNT_WIDTH'(CLEAR_CYCLES);
            pointer     <= '0;
            sync_valid  <= 1'b0;
            sync_data   <= '0;
            sync_clear  <= 1'b1;
        end else begin
            case (state)
                ST_CLEARING: begin
                    // Terminal count at 1 so the clear spans exactly CLEAR_CYCLES released cycles.
                    if (clear_count == COUNT_WIDTH'(1)) begin
                        state      <= ST_IDLE;
                        sync_clear <= 1'b0;
                    end
                    clear_count <= clear_count - COUNT_WIDTH'(1);
                end
                ST_IDLE: begin
                    if (|grant) begin
                        sync_data  <= {grant_index, grant_word};
                        sync_valid <= 1'b1;
                        pointer    <= next_pointer;
                        state      <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (sync_ready) begin
                        sync_valid <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state       <= ST_CLEARING;
                    clear_count <= COUNT_WIDTH'(CLEAR_CYCLES);
                    sync_valid  <= 1'b0;
                    sync_clear  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cdc_word_send_arbiter.sv
// Randomized self-checking bench for cdc_word_send_arbiter against a transfer-level model.
module tb_cdc_word_send_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int CC = 3;
    localparam int IW = 2;

    logic              clock = 1'b0;
    logic              clear_n;
    logic [N*W-1:0]    requester_data;
    logic [N-1:0]      requester_valid;
    logic [N-1:0]      requester_ready;
    logic [IW+W-1:0]   sync_data;
    logic              sync_valid;
    logic              sync_ready;
    logic              sync_clear;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    cdc_word_send_arbiter #(
        .REQUESTER_COUNT (N),
        .WORD_WIDTH      (W),
        .CLEAR_CYCLES    (CC)
    ) dut (
        .clock           (clock),
        .clear_n         (clear_n),
        .requester_data  (requester_data),
        .requester_valid (requester_valid),
        .requester_ready (requester_ready),
        .sync_data       (sync_data),
        .sync_valid      (sync_valid),
        .sync_ready      (sync_ready),
        .sync_clear      (sync_clear)
    );

    // Transfer-level reference: clear countdown, pending word, next-priority requester.
    bit              m_clearing = 1'b1;
    int              m_left     = CC;
    bit              m_busy     = 1'b0;
    int              m_ptr      = 0;
    logic [IW+W-1:0] m_data     = '0;

    function automatic int pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        logic [N-1:0] r;
        int g;
        r = '0;
        if (clear_n !== 1'b1 || m_clearing || m_busy) return r;
        g = pick(requester_valid, m_ptr);
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    task automatic model_edge();
        int g;
        if (clear_n === 1'b0) begin
            m_clearing = 1'b1;
            m_left     = CC;
            m_busy     = 1'b0;
            m_ptr      = 0;
            m_data     = '0;
        end else if (m_clearing) begin
            m_left--;
            if (m_left == 0) m_clearing = 1'b0;
        end else if (m_busy) begin
            if (sync_ready) m_busy = 1'b0;
        end else begin
            g = pick(requester_valid, m_ptr);
            if (g >= 0) begin
                m_data = {IW'(g), requester_data[g*W +: W]};
                m_ptr  = (g + 1) % N;
                m_busy = 1'b1;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clock);
        #2;
    endtask

    task automatic test_reset();
        clear_n = 1'b0;
        requester_valid = '1;
        requester_data = $urandom;
        sync_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            #1;
            checks++; if (sync_clear !== 1'b1) begin errors++; $display("FAIL reset_clear: got %b want 1", sync_clear); end
            checks++; if (sync_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", sync_valid); end
            checks++; if (requester_ready !== '0) begin errors++; $display("FAIL reset_ready: got %b want 0000", requester_ready); end
            checks++; if (sync_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 000", sync_data); end
        end
        clear_n = 1'b1;
        for (int c = 0; c < CC; c++) begin
            #1;
            checks++; if (sync_clear !== 1'b1) begin errors++; $display("FAIL clearing_%0d: sync_clear got %b want 1", c, sync_clear); end
            checks++; if (requester_ready !== '0 || sync_valid !== 1'b0) begin
                errors++; $display("FAIL clearing_quiet_%0d: ready %b valid %b want 0000 0", c, requester_ready, sync_valid);
            end
            tick();
        end
        #1;
        checks++; if (sync_clear !== 1'b0) begin errors++; $display("FAIL clear_end: got %b want 0", sync_clear); end
        checks++; if (requester_ready !== 4'b0001) begin errors++; $display("FAIL first_grant: got %b want 0001", requester_ready); end
        requester_valid = '0;
        tick();
    endtask

    task automatic test_all_valid();
        int sent, hi, have_held;
        logic [IW+W-1:0] held;
        int dut_g[$];
        sent = 0; hi = 0; have_held = 0; held = '0;
        requester_valid = '1;
        for (int cyc = 0; cyc < 300 && sent < 8; cyc++) begin
            requester_data = $urandom;
            sync_ready = 1'b0;
            if (sync_valid) begin
                hi++;
                if (hi == 6) begin sync_ready = 1'b1; sent++; hi = 0; end
            end else hi = 0;
            #1;
            for (int k = 0; k < N; k++) if (requester_ready[k]) dut_g.push_back(k);
            checks++; if (requester_ready !== exp_ready()) begin errors++; $display("FAIL all_ready: got %b want %b", requester_ready, exp_ready()); end
            checks++; if (sync_valid !== m_busy || sync_data !== m_data) begin
                errors++; $display("FAIL all_word: got %b/%h want %b/%h", sync_valid, sync_data, m_busy, m_data);
            end
            if (sync_valid && have_held == 0) begin
                held = sync_data; have_held = 1;
            end else if (sync_valid) begin
                checks++; if (sync_data !== held) begin errors++; $display("FAIL all_hold: got %h want %h", sync_data, held); end
            end else have_held = 0;
            tick();
        end
        requester_valid = '0;
        sync_ready = 1'b0;
        checks++; if (sent != 8) begin errors++; $display("FAIL all_timeout: transfers %0d want 8", sent); end
        checks++; if (dut_g.size() != 8) begin errors++; $display("FAIL all_count: grants %0d want 8", dut_g.size()); end
        for (int i = 0; i < dut_g.size() && i < 8; i++) begin
            checks++; if (dut_g[i] != i % N) begin errors++; $display("FAIL all_order_%0d: got %0d want %0d", i, dut_g[i], i % N); end
        end
        tick();
    endtask

    task automatic test_single();
        requester_data = $urandom;
        requester_data[2*W +: W] = 8'hA5;
        requester_valid = 4'b0100;
        #1;
        checks++; if (requester_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b want 0100", requester_ready); end
        tick();
        requester_valid = '0;
        requester_data = $urandom;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (requester_ready !== '0) begin errors++; $display("FAIL single_ready_once: got %b want 0000", requester_ready); end
            checks++; if (sync_valid !== 1'b1 || sync_data !== 10'h2A5) begin
                errors++; $display("FAIL single_word: got %b/%h want 1/2a5", sync_valid, sync_data);
            end
            tick();
        end
        sync_ready = 1'b1;
        tick();
        sync_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++; if (sync_valid !== 1'b0) begin errors++; $display("FAIL single_release: got %b want 0", sync_valid); end
            tick();
        end
    endtask

    task automatic test_busy_request();
        logic [W-1:0] word1;
        requester_data = $urandom;
        requester_valid = 4'b0001;
        #1;
        checks++; if (requester_ready !== 4'b0001) begin errors++; $display("FAIL busy_first: got %b want 0001", requester_ready); end
        tick();
        requester_valid = 4'b0010;
        word1 = requester_data[W +: W];
        for (int c = 0; c < 4; c++) begin
            if (c == 3) sync_ready = 1'b1;
            #1;
            checks++; if (requester_ready !== '0) begin errors++; $display("FAIL busy_wait_%0d: got %b want 0000", c, requester_ready); end
            tick();
        end
        sync_ready = 1'b0;
        #1;
        checks++; if (requester_ready !== 4'b0010) begin errors++; $display("FAIL busy_next: got %b want 0010", requester_ready); end
        checks++; if (sync_valid !== 1'b0) begin errors++; $display("FAIL busy_gap: got %b want 0", sync_valid); end
        tick();
        requester_valid = '0;
        #1;
        checks++; if (sync_data !== {2'd1, word1}) begin errors++; $display("FAIL busy_word: got %h want %h", sync_data, {2'd1, word1}); end
        sync_ready = 1'b1;
        tick();
        sync_ready = 1'b0;
    endtask

    task automatic test_stray_ready();
        requester_valid = '0;
        for (int c = 0; c < 3; c++) begin
            sync_ready = 1'b1;
            #1;
            checks++; if (requester_ready !== '0 || sync_valid !== 1'b0) begin
                errors++; $display("FAIL stray_%0d: ready %b valid %b want 0000 0", c, requester_ready, sync_valid);
            end
            tick();
        end
        sync_ready = 1'b0;
        requester_valid = '1;
        #1;
        checks++; if (requester_ready !== exp_ready()) begin errors++; $display("FAIL stray_ptr: got %b want %b", requester_ready, exp_ready()); end
        requester_valid = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        logic [IW+W-1:0] old_word, new_word;
        requester_data = $urandom;
        requester_valid = 4'b0100;
        tick();
        requester_valid = '0;
        #1;
        old_word = sync_data;
        checks++; if (sync_valid !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b want 1", sync_valid); end
        clear_n = 1'b0;
        tick();
        #1;
        checks++; if (sync_valid !== 1'b0 || sync_clear !== 1'b1 || sync_data !== '0) begin
            errors++; $display("FAIL mid_reset: valid %b clear %b data %h want 0 1 000", sync_valid, sync_clear, sync_data);
        end
        clear_n = 1'b1;
        requester_valid = '1;
        for (int c = 0; c < CC; c++) begin
            #1;
            checks++; if (requester_ready !== '0 || sync_valid !== 1'b0) begin
                errors++; $display("FAIL mid_clearing_%0d: ready %b valid %b want 0000 0", c, requester_ready, sync_valid);
            end
            tick();
        end
        #1;
        checks++; if (requester_ready !== 4'b0001) begin errors++; $display("FAIL mid_ptr: got %b want 0001", requester_ready); end
        new_word = {2'd0, requester_data[W-1:0]};
        tick();
        requester_valid = '0;
        #1;
        checks++; if (sync_data !== new_word || sync_data === old_word) begin
            errors++; $display("FAIL mid_word: got %h want %h (old %h)", sync_data, new_word, old_word);
        end
        sync_ready = 1'b1;
        tick();
        sync_ready = 1'b0;
    endtask

    task automatic test_random();
        int lat;
        lat = -1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            clear_n = ($urandom_range(0, 99) != 0);
            requester_valid = N'($urandom);
            requester_data = $urandom;
            sync_ready = 1'b0;
            if (sync_valid) begin
                if (lat < 0) lat = $urandom_range(0, 6);
                if (lat == 0) begin sync_ready = 1'b1; lat = -1; end
                else lat--;
            end else begin
                lat = -1;
                sync_ready = ($urandom_range(0, 29) == 0);
            end
            #1;
            checks++; if (requester_ready !== exp_ready()) begin errors++; $display("FAIL rand_ready@%0d: got %b want %b", cyc, requester_ready, exp_ready()); end
            checks++; if (sync_valid !== m_busy) begin errors++; $display("FAIL rand_valid@%0d: got %b want %b", cyc, sync_valid, m_busy); end
            checks++; if (sync_data !== m_data) begin errors++; $display("FAIL rand_data@%0d: got %h want %h", cyc, sync_data, m_data); end
            checks++; if (sync_clear !== m_clearing) begin errors++; $display("FAIL rand_clear@%0d: got %b want %b", cyc, sync_clear, m_clearing); end
            tick();
        end
    endtask

    initial begin
        clear_n = 1'b0;
        requester_valid = '0;
        requester_data = '0;
        sync_ready = 1'b0;
        test_reset();
        test_all_valid();
        test_single();
        test_busy_request();
        test_stray_ready();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
